imc_wb_slave_if: RTL and testbench

//  Wishbone classic slave front-end feeding the SRAM in-memory-compute top (SRAM_Wrapper_top).

---
 rtl/imc_wb_pkg.sv | 32 +++
 rtl/imc_wb_slave_if_if.sv | 27 ++
 rtl/imc_wb_reg_bank.sv | 65 ++++++
 rtl/imc_wb_slave_if.sv | 170 +++++++++++++++++
 tb/tb_imc_wb_slave_if.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imc_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imc_wb_pkg
// Brief    : Shared types and constants for the IMC Wishbone slave front-end
// Revision : 1.0 - initial release
// ============================================================================
package imc_wb_pkg;

    // Front-end transaction states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REG  = 2'd1,
        MEM  = 2'd2,
        ACK  = 2'd3
    } wb_state_t;

    // Register and memory-window offsets within the decoded window
    localparam logic [15:0] c_off_ctrl   = 16'h0000;
    localparam logic [15:0] c_off_status = 16'h0004;
    localparam logic [15:0] c_win_lo     = 16'h1000;
    localparam logic [15:0] c_win_hi     = 16'h13FC;

    // Read data returned when the core never answers
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // True when an offset falls inside the core memory window
    function automatic logic in_window(input logic [15:0] off);
        return (off >= c_win_lo) && (off <= c_win_hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imc_wb_slave_if_if.sv
`default_nettype none
// ============================================================================
// Module   : imc_wb_slave_if_if
// Brief    : Wishbone classic bus bundle between a master and the IMC slave
// Revision : 1.0 - initial release
// ============================================================================
interface imc_wb_slave_if_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/imc_wb_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : imc_wb_reg_bank
// Brief    : CTRL / STATUS registers, sticky timeout flag with W1C, interrupt
// Revision : 1.0 - initial release
// ============================================================================
module imc_wb_reg_bank
    import imc_wb_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        wr_en,
    input  wire logic [15:0] wr_offset,
    input  wire logic [2:0]  wr_data,
    input  wire logic        wr_sel0,
    input  wire logic        set_timeout,
    input  wire logic        busy,
    input  wire logic [15:0] rd_offset,
    output logic      [31:0] rd_data,
    output logic             imc_en_o,
    output logic             vclp_en_o,
    output logic             irq_o
);

    logic [2:0] r_ctrl;
    logic       r_timeout;
    logic       w_wr_ctrl;
    logic       w_wr_status;

    assign w_wr_ctrl   = wr_en && wr_sel0 && (wr_offset == c_off_ctrl);
    assign w_wr_status = wr_en && wr_sel0 && (wr_offset == c_off_status);

    // CTRL storage and sticky timeout flag; a new timeout beats a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl    <= 3'b000;
            r_timeout <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= wr_data;
            end
            if (set_timeout) begin
                r_timeout <= 1'b1;
            end else if (w_wr_status && wr_data[1]) begin
                r_timeout <= 1'b0;
            end
        end
    end

    // Read mux; unmapped offsets read as zero
    always_comb begin
        rd_data = 32'h0;
        if (rd_offset == c_off_ctrl) begin
            rd_data = {29'h0, r_ctrl};
        end else if (rd_offset == c_off_status) begin
            rd_data = {30'h0, r_timeout, busy};
        end
    end

    assign imc_en_o  = r_ctrl[0];
    assign vclp_en_o = r_ctrl[1];
    assign irq_o     = r_timeout & r_ctrl[2];

endmodule
`default_nettype wire

// File: rtl/imc_wb_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : imc_wb_slave_if
// Brief    : Wishbone classic slave front-end for the SRAM in-memory-compute
//            core: address decode, req/done core handshake, watchdog, ack
// Revision : 1.0 - initial release
// ============================================================================
module imc_wb_slave_if
    import imc_wb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
    parameter int          MEM_AW    = 8,
    parameter int          TIMEOUT   = 255
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    imc_wb_slave_if_if.slave       wb,
    output logic                   core_req_o,
    output logic                   core_we_o,
    output logic [MEM_AW-1:0]      core_addr_o,
    output logic [31:0]            core_wdata_o,
    output logic [3:0]             core_be_o,
    input  wire logic              core_done_i,
    input  wire logic [31:0]       core_rdata_i,
    output logic                   imc_en_o,
    output logic                   vclp_en_o,
    output logic                   irq_o
);

    localparam logic [7:0] c_wd_last = 8'(TIMEOUT - 1);

    wb_state_t         r_state;
    wb_state_t         w_next;
    logic [15:0]       r_offset;
    logic [MEM_AW-1:0] r_word;
    logic              r_we;
    logic [3:0]        r_sel;
    logic [31:0]       r_dat;
    logic [31:0]       r_rdata;
    logic              r_abort;
    logic [7:0]        r_wdog;

    logic [15:0]       w_offset;
    logic              w_start;
    logic              w_is_mem;
    logic              w_timeout;
    logic              w_abort;
    logic [31:0]       w_reg_rdata;
    logic              w_ack;
    logic              w_req;

    assign w_offset  = wb.wbs_adr_i[15:0];
    assign w_is_mem  = in_window(w_offset);
    assign w_start   = (r_state == IDLE) && wb.wbs_cyc_i && wb.wbs_stb_i
                       && ((wb.wbs_adr_i & ADDR_MASK) == ADDR_BASE);
    // Watchdog expiry; a completion arriving in the same cycle takes priority
    assign w_timeout = (r_state == MEM) && !core_done_i && (r_wdog == c_wd_last);
    // A master that has dropped cyc (now or earlier) gets no ack
    assign w_abort   = r_abort || !wb.wbs_cyc_i;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = w_is_mem ? MEM : REG;
                end
            end
            REG:  w_next = ACK;
            MEM: begin
                if (core_done_i || w_timeout) begin
                    w_next = w_abort ? IDLE : ACK;
                end
            end
            ACK:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bus and core handshake outputs, decoded from the registered state
    always_comb begin
        w_ack = 1'b0;
        w_req = 1'b0;
        case (r_state)
            MEM:     w_req = 1'b1;
            ACK:     w_ack = 1'b1;
            default: begin
                w_ack = 1'b0;
                w_req = 1'b0;
            end
        endcase
    end

    // Request latching, read data capture, abort tracking and watchdog
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_offset <= '0;
            r_word   <= '0;
            r_we     <= 1'b0;
            r_sel    <= 4'h0;
            r_dat    <= 32'h0;
            r_rdata  <= 32'h0;
            r_abort  <= 1'b0;
            r_wdog   <= 8'h0;
        end else begin
            if (r_state == MEM) begin
                r_wdog <= r_wdog + 8'd1;
            end else begin
                r_wdog <= 8'h0;
            end

            if (w_start) begin
                r_offset <= w_offset;
                r_word   <= wb.wbs_adr_i[MEM_AW+1:2];
                r_we     <= wb.wbs_we_i;
                r_sel    <= wb.wbs_sel_i;
                r_dat    <= wb.wbs_dat_i;
                r_abort  <= 1'b0;
                // Register reads are sampled at decode, while still idle
                r_rdata  <= wb.wbs_we_i ? 32'h0 : w_reg_rdata;
            end else if (r_state == MEM) begin
                if (!wb.wbs_cyc_i) begin
                    r_abort <= 1'b1;
                end
                if (core_done_i) begin
                    r_rdata <= r_we ? 32'h0 : core_rdata_i;
                end else if (w_timeout) begin
                    r_rdata <= TIMEOUT_DATA;
                end
            end
        end
    end

    imc_wb_reg_bank u_reg_bank (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       ((r_state == REG) && r_we),
        .wr_offset   (r_offset),
        .wr_data     (r_dat[2:0]),
        .wr_sel0     (r_sel[0]),
        .set_timeout (w_timeout),
        .busy        (r_state != IDLE),
        .rd_offset   (w_offset),
        .rd_data     (w_reg_rdata),
        .imc_en_o    (imc_en_o),
        .vclp_en_o   (vclp_en_o),
        .irq_o       (irq_o)
    );

    assign wb.wbs_ack_o = w_ack;
    assign wb.wbs_dat_o = w_ack ? r_rdata : 32'h0;
    assign core_req_o   = w_req;
    assign core_we_o    = w_req & r_we;
    assign core_addr_o  = w_req ? r_word : '0;
    assign core_wdata_o = w_req ? r_dat  : 32'h0;
    assign core_be_o    = w_req ? r_sel  : 4'h0;

endmodule
`default_nettype wire

// File: tb/tb_imc_wb_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_imc_wb_slave_if
// Brief    : Self-checking bench for imc_wb_slave_if with a behavioural core
//            memory and a byte-level reference memory
// Revision : 1.0 - initial release
// ============================================================================
module tb_imc_wb_slave_if;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        core_req_o, core_we_o, core_done_i;
    logic [7:0]  core_addr_o;
    logic [31:0] core_wdata_o, core_rdata_i;
    logic [3:0]  core_be_o;
    logic        imc_en_o, vclp_en_o, irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imc_wb_slave_if_if wb ();

    imc_wb_slave_if #(
        .ADDR_BASE (32'h3000_0000),
        .ADDR_MASK (32'hFFFF_0000),
        .MEM_AW    (8),
        .TIMEOUT   (TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wb           (wb),
        .core_req_o   (core_req_o),
        .core_we_o    (core_we_o),
        .core_addr_o  (core_addr_o),
        .core_wdata_o (core_wdata_o),
        .core_be_o    (core_be_o),
        .core_done_i  (core_done_i),
        .core_rdata_i (core_rdata_i),
        .imc_en_o     (imc_en_o),
        .vclp_en_o    (vclp_en_o),
        .irq_o        (irq_o)
    );

    // Behavioural SRAM core: answers a request after resp_delay cycles
    logic [31:0] core_mem [256];
    logic [31:0] ref_mem  [256];
    bit          resp_en = 1'b1;
    int          resp_delay = 0;
    int          resp_cnt = 0;
    bit          req_seen = 1'b0;
    logic [7:0]  seen_addr;
    logic [3:0]  seen_be;
    logic        seen_we;
    logic [31:0] seen_wdata;

    always @(negedge clk) begin
        core_done_i  = 1'b0;
        core_rdata_i = 32'h0;
        if (core_req_o) begin
            req_seen   = 1'b1;
            seen_addr  = core_addr_o;
            seen_be    = core_be_o;
            seen_we    = core_we_o;
            seen_wdata = core_wdata_o;
            if (resp_en) begin
                if (resp_cnt >= resp_delay) begin
                    core_done_i = 1'b1;
                    if (core_we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (core_be_o[b]) core_mem[core_addr_o][8*b +: 8] = core_wdata_o[8*b +: 8];
                    end else begin
                        core_rdata_i = core_mem[core_addr_o];
                    end
                    resp_cnt = 0;
                end else begin
                    resp_cnt++;
                end
            end
        end else begin
            resp_cnt = 0;
        end
    end

    // One bus transaction, preceded by an idle cycle; lat counts edges to ack
    task automatic wb_xfer(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                           input logic [31:0] dat, input int maxcyc,
                           output bit got, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_sel_i = sel;  wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;
        got = 1'b0; rd = 32'h0; lat = 0;
        for (int i = 1; i <= maxcyc; i++) begin
            @(posedge clk); #1;
            if (wb.wbs_ack_o) begin
                got = 1'b1; rd = wb.wbs_dat_o; lat = i;
                break;
            end
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    endtask

    task automatic ref_write(input int w, input logic [3:0] sel, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({wb.wbs_ack_o, wb.wbs_dat_o, core_req_o, core_addr_o, imc_en_o, vclp_en_o, irq_o} !== 45'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b dat=%h req=%b addr=%h en=%b vclp=%b irq=%b required all 0",
                     wb.wbs_ack_o, wb.wbs_dat_o, core_req_o, core_addr_o, imc_en_o, vclp_en_o, irq_o);
        end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_ctrl;
        bit got; logic [31:0] rd; int lat;
        wb_xfer(32'h3000_0000, 1'b1, 4'hF, 32'h3, 10, got, rd, lat);
        n_tests++;
        if (!got || lat != 2) begin n_fail++; $display("FAIL ctrl_write_lat: got=%b lat=%0d required ack at 2", got, lat); end
        @(posedge clk); #1;
        n_tests++;
        if (wb.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL ctrl_ack_width: ack=%b required 0", wb.wbs_ack_o); end
        n_tests++;
        if ({imc_en_o, vclp_en_o, irq_o} !== 3'b110) begin
            n_fail++; $display("FAIL ctrl_outputs: en/vclp/irq=%b required 110", {imc_en_o, vclp_en_o, irq_o});
        end
        wb_xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 10, got, rd, lat);
        n_tests++;
        if (rd !== 32'h3) begin n_fail++; $display("FAIL ctrl_read: got %h required 00000003", rd); end
        // sel[0] clear: write must be ignored
        wb_xfer(32'h3000_0000, 1'b1, 4'hE, 32'h0, 10, got, rd, lat);
        wb_xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 10, got, rd, lat);
        n_tests++;
        if (rd !== 32'h3) begin n_fail++; $display("FAIL ctrl_sel_gate: got %h required 00000003", rd); end
    endtask

    task automatic test_mem_write;
        bit got; logic [31:0] rd; int lat;
        resp_delay = 3; req_seen = 1'b0;
        wb_xfer(32'h3000_1010, 1'b1, 4'hF, 32'hA5A5_5A5A, 20, got, rd, lat);
        ref_write(4, 4'hF, 32'hA5A5_5A5A);
        n_tests++;
        if (!got || lat != 5) begin n_fail++; $display("FAIL memw_lat: got=%b lat=%0d required 5", got, lat); end
        n_tests++;
        if ({seen_addr, seen_be, seen_we, seen_wdata} !== {8'd4, 4'hF, 1'b1, 32'hA5A5_5A5A}) begin
            n_fail++; $display("FAIL memw_core_fields: addr=%h be=%h we=%b wdata=%h required 04 f 1 a5a55a5a",
                               seen_addr, seen_be, seen_we, seen_wdata);
        end
        n_tests++;
        if (core_mem[4] !== ref_mem[4]) begin n_fail++; $display("FAIL memw_stored: got %h required %h", core_mem[4], ref_mem[4]); end
    endtask

    task automatic test_mem_read;
        bit got; logic [31:0] rd; int lat;
        core_mem[4] = 32'h1234_5678; ref_mem[4] = 32'h1234_5678;
        resp_delay = 2;
        wb_xfer(32'h3000_1010, 1'b0, 4'hF, 32'h0, 20, got, rd, lat);
        n_tests++;
        if (!got || lat != 4 || rd !== 32'h1234_5678) begin
            n_fail++; $display("FAIL memr_data: got=%b lat=%0d dat=%h required 1 4 12345678", got, lat, rd);
        end
        @(posedge clk); #1;
        n_tests++;
        if (wb.wbs_ack_o !== 1'b0 || wb.wbs_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL memr_after: ack=%b dat=%h required 0 0", wb.wbs_ack_o, wb.wbs_dat_o);
        end
    endtask

    task automatic test_map_edges;
        bit got; logic [31:0] rd; int lat;
        req_seen = 1'b0;
        wb_xfer(32'h3000_0008, 1'b0, 4'hF, 32'h0, 10, got, rd, lat);
        n_tests++;
        if (!got || lat != 2 || rd !== 32'h0 || req_seen) begin
            n_fail++; $display("FAIL unmapped_0008: got=%b lat=%0d dat=%h req=%b required 1 2 0 0", got, lat, rd, req_seen);
        end
        wb_xfer(32'h3000_1400, 1'b0, 4'hF, 32'h0, 10, got, rd, lat);
        n_tests++;
        if (!got || lat != 2 || rd !== 32'h0 || req_seen) begin
            n_fail++; $display("FAIL unmapped_1400: got=%b lat=%0d dat=%h req=%b required 1 2 0 0", got, lat, rd, req_seen);
        end
        core_mem[255] = 32'hCAFE_0FF5; ref_mem[255] = 32'hCAFE_0FF5; resp_delay = 1;
        wb_xfer(32'h3000_13FC, 1'b0, 4'hF, 32'h0, 10, got, rd, lat);
        n_tests++;
        if (!got || rd !== 32'hCAFE_0FF5 || seen_addr !== 8'hFF) begin
            n_fail++; $display("FAIL window_top: got=%b dat=%h addr=%h required 1 cafe0ff5 ff", got, rd, seen_addr);
        end
    endtask

    task automatic test_no_hit;
        bit got; logic [31:0] rd; int lat;
        req_seen = 1'b0;
        wb_xfer(32'h2000_1010, 1'b0, 4'hF, 32'h0, 8, got, rd, lat);
        n_tests++;
        if (got || req_seen) begin n_fail++; $display("FAIL nohit_mem: ack=%b req=%b required 0 0", got, req_seen); end
        wb_xfer(32'h2000_0000, 1'b1, 4'hF, 32'h0, 8, got, rd, lat);
        n_tests++;
        if (got) begin n_fail++; $display("FAIL nohit_ack: ack=%b required 0", got); end
        wb_xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 10, got, rd, lat);
        n_tests++;
        if (rd !== 32'h3) begin n_fail++; $display("FAIL nohit_ctrl_kept: got %h required 00000003", rd); end
    endtask

    task automatic test_timeout;
        bit got; logic [31:0] rd; int lat;
        resp_en = 1'b0;
        wb_xfer(32'h3000_1020, 1'b0, 4'hF, 32'h0, 3 * TMO, got, rd, lat);
        resp_en = 1'b1;
        n_tests++;
        if (!got || rd !== 32'hDEAD_BEEF || lat < TMO || lat > TMO + 2) begin
            n_fail++; $display("FAIL timeout_ack: got=%b dat=%h lat=%0d required 1 deadbeef %0d..%0d", got, rd, lat, TMO, TMO + 2);
        end
        wb_xfer(32'h3000_0004, 1'b0, 4'hF, 32'h0, 10, got, rd, lat);
        n_tests++;
        if (rd !== 32'h2 || irq_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_status: status=%h irq=%b required 00000002 0", rd, irq_o);
        end
        wb_xfer(32'h3000_0000, 1'b1, 4'hF, 32'h7, 10, got, rd, lat);
        n_tests++;
        if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_enabled: irq=%b required 1", irq_o); end
        wb_xfer(32'h3000_0004, 1'b1, 4'h1, 32'h2, 10, got, rd, lat);
        wb_xfer(32'h3000_0004, 1'b0, 4'hF, 32'h0, 10, got, rd, lat);
        n_tests++;
        if (rd !== 32'h0 || irq_o !== 1'b0) begin
            n_fail++; $display("FAIL status_w1c: status=%h irq=%b required 00000000 0", rd, irq_o);
        end
        wb_xfer(32'h3000_0000, 1'b1, 4'hF, 32'h3, 10, got, rd, lat);
    endtask

    task automatic test_cyc_drop;
        bit got; logic [31:0] rd; int lat; bit ack_seen; int fell;
        resp_delay = 6;
        @(posedge clk); #1;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b1;
        wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = 32'h3000_1040; wb.wbs_dat_i = 32'h0BAD_F00D;
        repeat (2) @(posedge clk);
        #1;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        ack_seen = 1'b0; fell = 0;
        @(posedge clk); #1;
        n_tests++;
        if (core_req_o !== 1'b1) begin n_fail++; $display("FAIL drop_req_held: req=%b required 1", core_req_o); end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (wb.wbs_ack_o) ack_seen = 1'b1;
            if (!core_req_o && fell == 0) fell = i;
        end
        ref_write(16, 4'hF, 32'h0BAD_F00D);
        n_tests++;
        if (ack_seen || fell == 0 || core_mem[16] !== ref_mem[16]) begin
            n_fail++; $display("FAIL drop_drain: ack=%b req_fell_at=%0d mem=%h required 0 >0 %h", ack_seen, fell, core_mem[16], ref_mem[16]);
        end
        wb_xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 10, got, rd, lat);
        n_tests++;
        if (!got || lat != 2 || rd !== 32'h3) begin
            n_fail++; $display("FAIL drop_recover: got=%b lat=%0d dat=%h required 1 2 00000003", got, lat, rd);
        end
    endtask

    task automatic test_back_to_back;
        int a1, a2; logic [31:0] d1, d2;
        a1 = 0; a2 = 0; d1 = 0; d2 = 0;
        @(posedge clk); #1;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = 32'h3000_0000;
        for (int i = 1; i <= 12 && a2 == 0; i++) begin
            @(posedge clk); #1;
            if (wb.wbs_ack_o) begin
                if (a1 == 0) begin a1 = i; d1 = wb.wbs_dat_o; end
                else begin a2 = i; d2 = wb.wbs_dat_o; end
            end
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        n_tests++;
        if (a1 != 2 || a2 - a1 != 3 || d1 !== 32'h3 || d2 !== 32'h3) begin
            n_fail++; $display("FAIL back_to_back: ack1=%0d ack2=%0d d1=%h d2=%h required 2 5 3 3", a1, a2, d1, d2);
        end
    endtask

    task automatic test_random;
        bit got; logic [31:0] rd; int lat; int w; bit we; logic [3:0] sel; logic [31:0] d;
        for (int k = 0; k < 30; k++) begin
            w = $urandom_range(0, 7); we = 1'($urandom_range(0, 1));
            sel = 4'($urandom_range(1, 15)); d = $urandom; resp_delay = $urandom_range(0, 4);
            wb_xfer(32'h3000_1000 + 32'(w * 4), we, sel, d, 20, got, rd, lat);
            n_tests++;
            if (!got || lat != resp_delay + 2) begin
                n_fail++; $display("FAIL rand_lat[%0d]: got=%b lat=%0d required %0d", k, got, lat, resp_delay + 2);
            end
            if (we) begin
                ref_write(w, sel, d);
                n_tests++;
                if (seen_be !== sel || seen_addr !== 8'(w)) begin
                    n_fail++; $display("FAIL rand_wfields[%0d]: be=%h addr=%h required %h %h", k, seen_be, seen_addr, sel, w);
                end
            end else begin
                n_tests++;
                if (rd !== ref_mem[w]) begin
                    n_fail++; $display("FAIL rand_read[%0d]: got %h required %h", k, rd, ref_mem[w]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit got; logic [31:0] rd; int lat;
        wb_xfer(32'h3000_0000, 1'b1, 4'hF, 32'h1, 10, got, rd, lat);
        resp_en = 1'b0;
        @(posedge clk); #1;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = 32'h3000_1000;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (core_req_o !== 1'b1 || imc_en_o !== 1'b1) begin
            n_fail++; $display("FAIL midreset_pre: req=%b en=%b required 1 1", core_req_o, imc_en_o);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (core_req_o !== 1'b0 || wb.wbs_ack_o !== 1'b0 || imc_en_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset_async: req=%b ack=%b en=%b required 0 0 0", core_req_o, wb.wbs_ack_o, imc_en_o);
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        resp_en = 1'b1;
        @(negedge clk); reset_n = 1'b1;
        wb_xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 10, got, rd, lat);
        n_tests++;
        if (!got || lat != 2 || rd !== 32'h0 || core_req_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset_after: got=%b lat=%0d ctrl=%h req=%b required 1 2 0 0", got, lat, rd, core_req_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin core_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        core_done_i = 1'b0; core_rdata_i = 32'h0;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = 32'h0; wb.wbs_dat_i = 32'h0;
        test_reset;
        test_ctrl;
        test_mem_write;
        test_mem_read;
        test_map_edges;
        test_no_hit;
        test_timeout;
        test_cyc_drop;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
